// File: rtl/ex_hazard_ctrl_if.sv
// EX-stage hazard controller bundle: ID/EX/MEM request fields in,
// status and pipeline steering out.
interface ex_hazard_ctrl_if;
    // ID stage
    logic       id_valid;
    logic [3:0] id_src1;
    logic [3:0] id_src2;
    logic       id_two_src;
    // EX stage
    logic       ex_valid;
    logic [3:0] ex_cond;
    logic       ex_s;
    logic       ex_b;
    logic       ex_wb_en;
    logic       ex_mem_r_en;
    logic [3:0] ex_dest;
    logic [3:0] alu_status;
    // MEM stage
    logic       mem_valid;
    logic       mem_r_en;
    logic       mem_w_en;
    logic       mem_wb_en;
    logic [3:0] mem_dest;
    // controller outputs
    logic [3:0] status;
    logic       ex_commit;
    logic       branch_taken;
    logic       flush;
    logic       freeze_all;
    logic       freeze_front;
    logic       bubble;

    // pipeline side: drives stage fields, consumes steering
    modport master (
        output id_valid, id_src1, id_src2, id_two_src,
        output ex_valid, ex_cond, ex_s, ex_b, ex_wb_en, ex_mem_r_en, ex_dest, alu_status,
        output mem_valid, mem_r_en, mem_w_en, mem_wb_en, mem_dest,
        input  status, ex_commit, branch_taken, flush, freeze_all, freeze_front, bubble
    );

    // controller side
    modport slave (
        input  id_valid, id_src1, id_src2, id_two_src,
        input  ex_valid, ex_cond, ex_s, ex_b, ex_wb_en, ex_mem_r_en, ex_dest, alu_status,
        input  mem_valid, mem_r_en, mem_w_en, mem_wb_en, mem_dest,
        output status, ex_commit, branch_taken, flush, freeze_all, freeze_front, bubble
    );
endinterface

// File: rtl/ex_hazard_ctrl.sv
// EX-stage pipeline controller: NZCV register, ARM condition evaluation,
// branch flush, load-use / RAW stall and MEM-access freeze sequencing.
// Status layout is {N,Z,C,V} on bits [3:0].
module ex_hazard_ctrl #(
    parameter int WAIT_CYCLES = 2,
    parameter bit FORWARD_EN  = 1'b1
) (
    input logic             clk,
    input logic             rst,
    ex_hazard_ctrl_if.slave hz_if
);

    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT =
        (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       status_q, status_d;

    logic mem_req;
    logic freeze;
    logic cond_pass;
    logic commit;
    logic take_br;
    logic match_ex, match_mem, hz;

    wire flg_n = status_q[3];
    wire flg_z = status_q[2];
    wire flg_c = status_q[1];
    wire flg_v = status_q[0];

    assign mem_req = hz_if.mem_valid & (hz_if.mem_r_en | hz_if.mem_w_en);

    // Freeze sequencer: first frozen cycle is the one the access is seen in,
    // then count down; the cnt==0 cycle releases and cannot re-trigger.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        freeze  = 1'b0;
        if (state_q == ST_RUN) begin
            if (mem_req && (WAIT_CYCLES > 0)) begin
                freeze  = 1'b1;
                state_d = ST_WAIT;
                cnt_d   = CNT_INIT;
            end
        end else begin
            if (cnt_q != '0) begin
                freeze = 1'b1;
                cnt_d  = cnt_q - 1'b1;
            end else begin
                state_d = ST_RUN;
            end
        end
        // reset wins: nothing is frozen while rst is held
        if (rst) freeze = 1'b0;
    end

    // ARM condition-code evaluation against the registered flags
    always_comb begin
        cond_pass = 1'b0;
        case (hz_if.ex_cond)
            4'b0000: cond_pass = flg_z;
            4'b0001: cond_pass = !flg_z;
            4'b0010: cond_pass = flg_c;
            4'b0011: cond_pass = !flg_c;
            4'b0100: cond_pass = flg_n;
            4'b0101: cond_pass = !flg_n;
            4'b0110: cond_pass = flg_v;
            4'b0111: cond_pass = !flg_v;
            4'b1000: cond_pass = flg_c & !flg_z;
            4'b1001: cond_pass = !flg_c | flg_z;
            4'b1010: cond_pass = (flg_n == flg_v);
            4'b1011: cond_pass = (flg_n != flg_v);
            4'b1100: cond_pass = !flg_z & (flg_n == flg_v);
            4'b1101: cond_pass = flg_z | (flg_n != flg_v);
            default: cond_pass = 1'b1;   // AL and 1111
        endcase
    end

    // Commit / branch / hazard steering; priority freeze > flush > stall
    always_comb begin
        commit  = !rst & hz_if.ex_valid & cond_pass & !freeze;
        take_br = commit & hz_if.ex_b;

        match_ex = hz_if.ex_valid & hz_if.ex_wb_en &
                   ((hz_if.id_src1 == hz_if.ex_dest) |
                    (hz_if.id_two_src & (hz_if.id_src2 == hz_if.ex_dest)));
        // with forwarding only a load result is unavailable in time
        if (FORWARD_EN) match_ex = match_ex & hz_if.ex_mem_r_en;

        match_mem = hz_if.mem_valid & hz_if.mem_wb_en &
                    ((hz_if.id_src1 == hz_if.mem_dest) |
                     (hz_if.id_two_src & (hz_if.id_src2 == hz_if.mem_dest)));

        hz = !rst & hz_if.id_valid & !freeze &
             (match_ex | (!FORWARD_EN & match_mem));
    end

    // Flag update only for an executing S-suffixed instruction
    always_comb begin
        status_d = status_q;
        if (commit && hz_if.ex_s) status_d = hz_if.alu_status;
    end

    // State, counter and flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_RUN;
            cnt_q    <= '0;
            status_q <= 4'b0000;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            status_q <= status_d;
        end
    end

    assign hz_if.status       = rst ? 4'b0000 : status_q;
    assign hz_if.ex_commit    = commit;
    assign hz_if.branch_taken = take_br;
    assign hz_if.flush        = take_br;
    assign hz_if.freeze_all   = freeze;
    assign hz_if.freeze_front = hz & !take_br;
    assign hz_if.bubble       = hz & !take_br;

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Scoreboard bench for ex_hazard_ctrl (WAIT_CYCLES=2, FORWARD_EN=1).
// Each step drives inputs, pushes the hand-derived expected outputs,
// and the negedge monitor pops and compares.
module tb_ex_hazard_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ex_hazard_ctrl_if bus ();

    ex_hazard_ctrl #(.WAIT_CYCLES(2), .FORWARD_EN(1'b1)) dut (
        .clk   (clk),
        .rst   (rst),
        .hz_if (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    logic [9:0] exp_q[$];
    string      tag_q[$];

    task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s obs=%b exp=%b (status,commit,br,flush,fa,ff,bub)", tag, obs, exp);
        end
    endtask

    // {status[3:0], ex_commit, branch_taken, flush, freeze_all, freeze_front, bubble}
    function automatic logic [9:0] e(input logic [3:0] st, input logic c, input logic br,
                                     input logic fl, input logic fa, input logic ff,
                                     input logic bu);
        return {st, c, br, fl, fa, ff, bu};
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            chk(tag_q.pop_front(),
                {bus.status, bus.ex_commit, bus.branch_taken, bus.flush,
                 bus.freeze_all, bus.freeze_front, bus.bubble},
                exp_q.pop_front());
        end
    end

    task automatic idle();
        rst = 1'b0;
        bus.id_valid = 1'b0; bus.id_src1 = 4'd0; bus.id_src2 = 4'd0; bus.id_two_src = 1'b0;
        bus.ex_valid = 1'b0; bus.ex_cond = 4'b1110; bus.ex_s = 1'b0; bus.ex_b = 1'b0;
        bus.ex_wb_en = 1'b0; bus.ex_mem_r_en = 1'b0; bus.ex_dest = 4'd0; bus.alu_status = 4'd0;
        bus.mem_valid = 1'b0; bus.mem_r_en = 1'b0; bus.mem_w_en = 1'b0;
        bus.mem_wb_en = 1'b0; bus.mem_dest = 4'd0;
    endtask

    // one clock: queue the expectation, let the monitor sample, advance
    task automatic cyc(input string tag, input logic [9:0] ex);
        exp_q.push_back(ex);
        tag_q.push_back(tag);
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic alu_op(input logic [3:0] cond, input logic s, input logic [3:0] alu);
        bus.ex_valid = 1'b1; bus.ex_cond = cond; bus.ex_s = s; bus.alu_status = alu;
    endtask

    task automatic load_use(input logic [3:0] dst);
        bus.ex_valid = 1'b1; bus.ex_wb_en = 1'b1; bus.ex_mem_r_en = 1'b1; bus.ex_dest = dst;
        bus.id_valid = 1'b1; bus.id_src1 = dst;
    endtask

    initial begin
        // T1: reset with live requests everywhere
        idle();
        rst = 1'b1;
        bus.mem_valid = 1'b1; bus.mem_r_en = 1'b1;
        bus.ex_valid = 1'b1; bus.ex_b = 1'b1; bus.ex_s = 1'b1; bus.alu_status = 4'b1111;
        cyc("rst0", e(4'b0000, 0, 0, 0, 0, 0, 0));
        cyc("rst1", e(4'b0000, 0, 0, 0, 0, 0, 0));
        idle();
        cyc("idle", e(4'b0000, 0, 0, 0, 0, 0, 0));

        // T2: load held in MEM for the whole freeze
        bus.mem_valid = 1'b1; bus.mem_r_en = 1'b1;
        cyc("ld_t0", e(4'b0000, 0, 0, 0, 1, 0, 0));
        cyc("ld_t1", e(4'b0000, 0, 0, 0, 1, 0, 0));
        cyc("ld_t2_rel", e(4'b0000, 0, 0, 0, 0, 0, 0));
        idle();
        cyc("ld_t3", e(4'b0000, 0, 0, 0, 0, 0, 0));
        bus.mem_valid = 1'b1; bus.mem_w_en = 1'b1;
        cyc("st_t0", e(4'b0000, 0, 0, 0, 1, 0, 0));
        cyc("st_t1", e(4'b0000, 0, 0, 0, 1, 0, 0));
        cyc("st_t2_rel", e(4'b0000, 0, 0, 0, 0, 0, 0));
        idle();

        // T3: flags and condition codes
        alu_op(4'b1110, 1'b1, 4'b0100);
        cyc("s_al", e(4'b0000, 1, 0, 0, 0, 0, 0));
        alu_op(4'b0000, 1'b0, 4'b0000);
        cyc("eq", e(4'b0100, 1, 0, 0, 0, 0, 0));
        alu_op(4'b0001, 1'b1, 4'b1111);
        cyc("ne_s", e(4'b0100, 0, 0, 0, 0, 0, 0));
        alu_op(4'b1110, 1'b0, 4'b0000);
        cyc("held", e(4'b0100, 1, 0, 0, 0, 0, 0));
        alu_op(4'b1100, 1'b0, 4'b0000);
        cyc("gt_z", e(4'b0100, 0, 0, 0, 0, 0, 0));
        alu_op(4'b1001, 1'b0, 4'b0000);
        cyc("ls_z", e(4'b0100, 1, 0, 0, 0, 0, 0));
        alu_op(4'b1000, 1'b0, 4'b0000);
        cyc("hi_z", e(4'b0100, 0, 0, 0, 0, 0, 0));
        alu_op(4'b0011, 1'b0, 4'b0000);
        cyc("cc", e(4'b0100, 1, 0, 0, 0, 0, 0));
        alu_op(4'b1110, 1'b1, 4'b1001);
        cyc("s_nv", e(4'b0100, 1, 0, 0, 0, 0, 0));
        alu_op(4'b1010, 1'b0, 4'b0000);
        cyc("ge", e(4'b1001, 1, 0, 0, 0, 0, 0));
        alu_op(4'b1011, 1'b0, 4'b0000);
        cyc("lt", e(4'b1001, 0, 0, 0, 0, 0, 0));
        alu_op(4'b1100, 1'b0, 4'b0000);
        cyc("gt", e(4'b1001, 1, 0, 0, 0, 0, 0));
        alu_op(4'b1101, 1'b0, 4'b0000);
        cyc("le", e(4'b1001, 0, 0, 0, 0, 0, 0));
        alu_op(4'b0101, 1'b0, 4'b0000);
        cyc("pl", e(4'b1001, 0, 0, 0, 0, 0, 0));
        alu_op(4'b0110, 1'b0, 4'b0000);
        cyc("vs", e(4'b1001, 1, 0, 0, 0, 0, 0));
        alu_op(4'b0010, 1'b0, 4'b0000);
        cyc("cs", e(4'b1001, 0, 0, 0, 0, 0, 0));
        alu_op(4'b1111, 1'b0, 4'b0000);
        cyc("nv_always", e(4'b1001, 1, 0, 0, 0, 0, 0));
        idle();

        // T4: hazard detection, status stays 1001
        load_use(4'd3);
        cyc("lu_src1", e(4'b1001, 1, 0, 0, 0, 1, 1));
        bus.id_src1 = 4'd5; bus.id_src2 = 4'd3; bus.id_two_src = 1'b0;
        cyc("lu_src2_unused", e(4'b1001, 1, 0, 0, 0, 0, 0));
        bus.id_two_src = 1'b1;
        cyc("lu_src2", e(4'b1001, 1, 0, 0, 0, 1, 1));
        bus.id_src1 = 4'd3; bus.id_two_src = 1'b0; bus.ex_mem_r_en = 1'b0;
        cyc("fwd_alu", e(4'b1001, 1, 0, 0, 0, 0, 0));
        bus.ex_dest = 4'd7;
        bus.mem_valid = 1'b1; bus.mem_wb_en = 1'b1; bus.mem_dest = 4'd3;
        cyc("fwd_mem", e(4'b1001, 1, 0, 0, 0, 0, 0));
        idle();
        load_use(4'd3);
        bus.id_valid = 1'b0;
        cyc("lu_id_inv", e(4'b1001, 1, 0, 0, 0, 0, 0));
        idle();

        // T5: flush beats stall; failed branch leaves the stall in place
        load_use(4'd3);
        bus.ex_b = 1'b1;
        cyc("br_over_lu", e(4'b1001, 1, 1, 1, 0, 0, 0));
        bus.ex_cond = 4'b0000;
        cyc("br_eq_fail", e(4'b1001, 0, 0, 0, 0, 1, 1));
        idle();

        // T6: branch held in EX across a MEM freeze
        load_use(4'd3);
        bus.ex_b = 1'b1; bus.ex_s = 1'b1; bus.alu_status = 4'b0010;
        bus.mem_valid = 1'b1; bus.mem_r_en = 1'b1;
        cyc("frz_br_t0", e(4'b1001, 0, 0, 0, 1, 0, 0));
        cyc("frz_br_t1", e(4'b1001, 0, 0, 0, 1, 0, 0));
        cyc("frz_br_t2", e(4'b1001, 1, 1, 1, 0, 0, 0));
        idle();
        cyc("frz_br_t3", e(4'b0010, 0, 0, 0, 0, 0, 0));

        // T6 again, reset aborts the wait
        bus.ex_valid = 1'b1; bus.ex_b = 1'b1; bus.ex_s = 1'b1; bus.alu_status = 4'b0110;
        bus.mem_valid = 1'b1; bus.mem_r_en = 1'b1;
        cyc("rst_wait_t0", e(4'b0010, 0, 0, 0, 1, 0, 0));
        rst = 1'b1;
        cyc("rst_wait_t1", e(4'b0000, 0, 0, 0, 0, 0, 0));
        rst = 1'b0; bus.mem_valid = 1'b0; bus.mem_r_en = 1'b0;
        cyc("rst_wait_t2", e(4'b0000, 1, 1, 1, 0, 0, 0));
        idle();
        cyc("rst_wait_t3", e(4'b0110, 0, 0, 0, 0, 0, 0));

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL sb_drain obs=%0d exp=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
